// File: rtl/uart_cmd_bus_master.sv
// Serial command framer: turns command bytes from a UART receiver into single-cycle
// 16-bit register-bus transactions and returns read data to the UART transmitter MSB first.
module uart_cmd_bus_master #(
  parameter int unsigned RD_TIMEOUT   = 15,
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic        i_Bus_Rst_L,
  input  logic        i_Bus_Clk,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Tx_Ready,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [4:0]  o_Bus_Addr8,
  output logic [15:0] o_Bus_Wr_Data,
  input  logic [15:0] i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV,
  output logic        o_Busy,
  output logic        o_Err
);

  // state       | meaning
  // S_IDLE      | waiting for a command byte
  // S_GET_MSB   | write frame, waiting for data MSB
  // S_GET_LSB   | write frame, waiting for data LSB
  // S_WR_ISSUE  | write strobe on the bus
  // S_RD_ISSUE  | read strobe on the bus
  // S_RD_WAIT   | waiting for slave read data or read timeout
  // S_TX_MSB    | waiting for transmitter to take response[15:8]
  // S_TX_GUARD1 | one cycle for the transmitter to drop ready
  // S_TX_LSB    | waiting for transmitter to take response[7:0]
  // S_TX_GUARD2 | one cycle for the transmitter to drop ready
  typedef enum logic [3:0] {
    S_IDLE, S_GET_MSB, S_GET_LSB, S_WR_ISSUE, S_RD_ISSUE,
    S_RD_WAIT, S_TX_MSB, S_TX_GUARD1, S_TX_LSB, S_TX_GUARD2
  } state_t;

  localparam logic [19:0] BYTE_LAST = 20'(BYTE_TIMEOUT - 1);
  localparam logic [7:0]  RD_LAST   = 8'(RD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [19:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]  rd_cnt, rd_cnt_nxt;
  logic [4:0]  addr, addr_nxt;
  logic [15:0] wr_data, wr_data_nxt;
  logic [15:0] resp, resp_nxt;
  logic        cs, wr_rd_n, tx_dv, err;
  logic [7:0]  tx_byte;
  logic        unused_cmd_bit0;

  assign unused_cmd_bit0 = i_Rx_Byte[0];

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      rd_cnt   <= '0;
      addr     <= '0;
      wr_data  <= '0;
      resp     <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      rd_cnt   <= rd_cnt_nxt;
      addr     <= addr_nxt;
      wr_data  <= wr_data_nxt;
      resp     <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    rd_cnt_nxt   = rd_cnt;
    addr_nxt     = addr;
    wr_data_nxt  = wr_data;
    resp_nxt     = resp;
    cs           = 1'b0;
    wr_rd_n      = 1'b0;
    tx_dv        = 1'b0;
    tx_byte      = '0;
    err          = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte[6:5] != 2'b00) begin
            err = 1'b1;
          end else begin
            addr_nxt     = {i_Rx_Byte[4:1], 1'b0};
            byte_cnt_nxt = '0;
            state_nxt    = i_Rx_Byte[7] ? S_GET_MSB : S_RD_ISSUE;
          end
        end
      end
      S_GET_MSB, S_GET_LSB: begin
        // a byte arriving on the timeout cycle still wins
        if (i_Rx_DV) begin
          byte_cnt_nxt = '0;
          if (state == S_GET_MSB) begin
            wr_data_nxt[15:8] = i_Rx_Byte;
            state_nxt         = S_GET_LSB;
          end else begin
            wr_data_nxt[7:0] = i_Rx_Byte;
            state_nxt        = S_WR_ISSUE;
          end
        end else if (byte_cnt == BYTE_LAST) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          byte_cnt_nxt = (byte_cnt == '1) ? byte_cnt : byte_cnt + 20'd1;
        end
      end
      S_WR_ISSUE: begin
        cs        = 1'b1;
        wr_rd_n   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RD_ISSUE: begin
        cs         = 1'b1;
        rd_cnt_nxt = '0;
        state_nxt  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_Bus_Rd_DV) begin
          resp_nxt  = i_Bus_Rd_Data;
          state_nxt = S_TX_MSB;
        end else if (rd_cnt == RD_LAST) begin
          resp_nxt  = TIMEOUT_DATA;
          err       = 1'b1;
          state_nxt = S_TX_MSB;
        end else begin
          rd_cnt_nxt = (rd_cnt == '1) ? rd_cnt : rd_cnt + 8'd1;
        end
      end
      S_TX_MSB: begin
        tx_byte = resp[15:8];
        if (i_Tx_Ready) begin
          tx_dv     = 1'b1;
          state_nxt = S_TX_GUARD1;
        end
      end
      S_TX_GUARD1: state_nxt = S_TX_LSB;
      S_TX_LSB: begin
        tx_byte = resp[7:0];
        if (i_Tx_Ready) begin
          tx_dv     = 1'b1;
          state_nxt = S_TX_GUARD2;
        end
      end
      S_TX_GUARD2: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase

    // bytes arriving while a transaction or response is in flight are dropped
    if (i_Rx_DV && state != S_IDLE && state != S_GET_MSB && state != S_GET_LSB) begin
      err = 1'b1;
    end
  end

  assign o_Bus_CS      = cs;
  assign o_Bus_Wr_Rd_n = wr_rd_n;
  assign o_Bus_Addr8   = addr;
  assign o_Bus_Wr_Data = wr_data;
  assign o_Tx_DV       = tx_dv;
  assign o_Tx_Byte     = tx_byte;
  assign o_Busy        = (state != S_IDLE);
  assign o_Err         = err;

endmodule

// File: tb/tb_uart_cmd_bus_master.sv
// Bench for uart_cmd_bus_master: directed command frames, an expectation scoreboard
// built from the command encoding, and a monitor that checks every bus strobe and Tx byte.
module tb_uart_cmd_bus_master;

  localparam int          RD_TO   = 15;
  localparam int          BYTE_TO = 40;
  localparam logic [15:0] TO_DATA = 16'hDEAD;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        bus_cs;
  logic        bus_wr;
  logic [4:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] rd_data;
  logic        rd_dv;
  logic        busy;
  logic        err;

  uart_cmd_bus_master #(
    .RD_TIMEOUT  (RD_TO),
    .BYTE_TIMEOUT(BYTE_TO),
    .TIMEOUT_DATA(TO_DATA)
  ) dut (
    .i_Bus_Rst_L  (rst_n),
    .i_Bus_Clk    (clk),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .i_Tx_Ready   (tx_ready),
    .o_Tx_DV      (tx_dv),
    .o_Tx_Byte    (tx_byte),
    .o_Bus_CS     (bus_cs),
    .o_Bus_Wr_Rd_n(bus_wr),
    .o_Bus_Addr8  (bus_addr),
    .o_Bus_Wr_Data(bus_wdata),
    .i_Bus_Rd_Data(rd_data),
    .i_Bus_Rd_DV  (rd_dv),
    .o_Busy       (busy),
    .o_Err        (err)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_exp = 0;
  int tx_count = 0;
  int last_rx_cyc = 0;
  int last_cs_cyc = 0;
  int last_err_cyc = 0;
  logic [4:0]  last_cs_addr = '0;
  logic [15:0] last_cs_data = '0;
  logic [7:0]  tx_prev = '0;
  logic [7:0]  tx_last = '0;
  logic        prev_cs = 1'b0;
  logic        tx_hold = 1'b0;
  logic        slave_en = 1'b0;
  logic [15:0] slave_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // model: what a command byte must do on the bus and on the serial return path
  function automatic logic [4:0] cmd_addr(input logic [7:0] cmd);
    return 5'(((cmd % 32) / 2) * 2);
  endfunction

  task automatic expect_cmd(input logic [7:0] cmd, input logic [15:0] wdata,
                            input logic rd_ok, input logic [15:0] rdata);
    bus_t e;
    logic [15:0] r;
    if (((cmd / 32) % 4) != 0) begin
      err_exp++;
    end else begin
      e.wr   = (cmd >= 128);
      e.addr = cmd_addr(cmd);
      e.data = wdata;
      exp_bus.push_back(e);
      if (!e.wr) begin
        r = rd_ok ? rdata : TO_DATA;
        exp_tx.push_back(8'(r / 256));
        exp_tx.push_back(8'(r % 256));
        if (!rd_ok) err_exp++;
      end
    end
  endtask

  // monitor: every strobe and every Tx byte is checked against the scoreboard
  initial forever begin
    bus_t e;
    @(negedge clk);
    if (rst_n) begin
      if (bus_cs) begin
        chk("cs_single_cycle", prev_cs, 1'b0);
        last_cs_cyc  = cyc;
        last_cs_addr = bus_addr;
        last_cs_data = bus_wdata;
        if (exp_bus.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cs wr=%0b addr=%0h data=%0h required=none", bus_wr, bus_addr, bus_wdata);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_wr_rd_n", bus_wr, e.wr);
          chk("bus_addr8", bus_addr, e.addr);
          if (e.wr) chk("bus_wr_data", bus_wdata, e.data);
        end
      end
      if (tx_dv) begin
        chk("tx_gated_by_ready", tx_ready, 1'b1);
        tx_count++;
        tx_prev = tx_last;
        tx_last = tx_byte;
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tx byte=%0h required=none", tx_byte);
        end else begin
          chk("tx_byte", tx_byte, exp_tx.pop_front());
        end
      end
      if (err) begin
        err_seen++;
        last_err_cyc = cyc;
      end
      prev_cs = bus_cs;
    end else begin
      prev_cs = 1'b0;
    end
  end

  // transmitter: busy for a few cycles after each accepted byte
  initial begin
    int   tx_busy;
    logic dv_now;
    tx_busy  = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      dv_now = tx_dv;
      @(posedge clk);
      #1;
      if (dv_now) tx_busy = 3;
      else if (tx_busy != 0) tx_busy--;
      tx_ready = (tx_busy == 0) && !tx_hold;
    end
  end

  // slave: read data one cycle after a read strobe, when enabled
  initial forever begin
    @(negedge clk);
    if (rst_n && bus_cs && !bus_wr && slave_en) begin
      @(posedge clk);
      #1;
      rd_dv   = 1'b1;
      rd_data = slave_data;
      @(posedge clk);
      #1;
      rd_dv = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    rx_dv       = 1'b1;
    rx_byte     = b;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_done_in_budget"}, n < budget, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic seg_end(input string nm);
    chk({nm, "_err_count"}, err_seen, err_exp);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tx_dv"}, tx_dv, 1'b0);
    chk({nm, "_tx_byte"}, tx_byte, 8'h00);
    chk({nm, "_cs"}, bus_cs, 1'b0);
    chk({nm, "_wr_rd_n"}, bus_wr, 1'b0);
    chk({nm, "_addr8"}, bus_addr, 5'h00);
    chk({nm, "_wr_data"}, bus_wdata, 16'h0000);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_err"}, err, 1'b0);
  endtask

  initial begin
    int tx0;
    logic [7:0] rsv [3];
    bus_t e;
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = '0;
    rd_dv   = 1'b0;
    rd_data = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_busy", busy, 1'b0);

    // write 0x1234 to register 3
    expect_cmd(8'h86, 16'h1234, 1'b0, 16'h0);
    send_byte(8'h86, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    wait_idle(50, "write");
    chk("write_latency", last_cs_cyc - last_rx_cyc, 1);
    chk("write_addr_lit", last_cs_addr, 5'h06);
    chk("write_data_lit", last_cs_data, 16'h1234);
    chk("write_no_tx", tx_count, 0);
    seg_end("write");

    // read register 5, slave answers 0xBEEF
    slave_en   = 1'b1;
    slave_data = 16'hBEEF;
    tx0 = tx_count;
    expect_cmd(8'h0A, 16'h0, 1'b1, 16'hBEEF);
    send_byte(8'h0A, 0);
    wait_idle(100, "read");
    chk("read_issue_latency", last_cs_cyc - last_rx_cyc, 1);
    chk("read_addr_lit", last_cs_addr, 5'h0A);
    chk("read_tx_count", tx_count - tx0, 2);
    chk("read_tx_msb_lit", tx_prev, 8'hBE);
    chk("read_tx_lsb_lit", tx_last, 8'hEF);
    seg_end("read");

    // read with no slave answer
    slave_en = 1'b0;
    tx0 = tx_count;
    expect_cmd(8'h1E, 16'h0, 1'b0, 16'h0);
    send_byte(8'h1E, 0);
    wait_idle(100, "rd_timeout");
    chk("rd_timeout_err_delay", last_err_cyc - last_cs_cyc, RD_TO);
    chk("rd_timeout_addr_lit", last_cs_addr, 5'h1E);
    chk("rd_timeout_tx_count", tx_count - tx0, 2);
    chk("rd_timeout_msb_lit", tx_prev, 8'hDE);
    chk("rd_timeout_lsb_lit", tx_last, 8'hAD);
    seg_end("rd_timeout");

    // partial write frame abandoned, then a full one
    err_exp++;
    send_byte(8'h82, 0);
    send_byte(8'h55, 0);
    wait_idle(BYTE_TO + 20, "partial");
    chk("partial_err_delay", last_err_cyc - last_rx_cyc, BYTE_TO);
    seg_end("partial");
    expect_cmd(8'h82, 16'hAA01, 1'b0, 16'h0);
    send_byte(8'h82, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h01, 0);
    wait_idle(50, "after_partial");
    chk("after_partial_addr_lit", last_cs_addr, 5'h02);
    chk("after_partial_data_lit", last_cs_data, 16'hAA01);
    seg_end("after_partial");

    // gaps shorter than the timeout, longer in total: counter must reload per byte
    expect_cmd(8'h90, 16'hC35A, 1'b0, 16'h0);
    send_byte(8'h90, 0);
    send_byte(8'hC3, 30);
    send_byte(8'h5A, 30);
    wait_idle(50, "gap_reload");
    chk("gap_reload_addr_lit", last_cs_addr, 5'h10);
    chk("gap_reload_data_lit", last_cs_data, 16'hC35A);
    seg_end("gap_reload");

    // reserved bits set
    rsv[0] = 8'hE0;
    rsv[1] = 8'h20;
    rsv[2] = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      expect_cmd(rsv[i], 16'h0, 1'b0, 16'h0);
      send_byte(rsv[i], 0);
      wait_idle(10, "reserved");
    end
    seg_end("reserved");

    // stray read-valid outside a read
    @(posedge clk);
    #1;
    rd_dv = 1'b1;
    @(posedge clk);
    #1;
    rd_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    seg_end("stray_rd_dv");

    // overrun while the transmitter is held busy
    tx_hold    = 1'b1;
    slave_en   = 1'b1;
    slave_data = 16'h5A3C;
    tx0 = tx_count;
    expect_cmd(8'h04, 16'h0, 1'b1, 16'h5A3C);
    send_byte(8'h04, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("overrun_busy_before", busy, 1'b1);
    chk("overrun_no_tx_yet", tx_count - tx0, 0);
    err_exp++;
    send_byte(8'h99, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("overrun_err", err_seen, err_exp);
    chk("overrun_still_busy", busy, 1'b1);
    tx_hold = 1'b0;
    wait_idle(100, "overrun");
    chk("overrun_tx_count", tx_count - tx0, 2);
    chk("overrun_msb_lit", tx_prev, 8'h5A);
    chk("overrun_lsb_lit", tx_last, 8'h3C);
    seg_end("overrun");

    // reset while waiting for read data
    slave_en = 1'b0;
    e.wr   = 1'b0;
    e.addr = 5'h0C;
    e.data = 16'h0;
    exp_bus.push_back(e);
    send_byte(8'h0C, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_reset_busy_before", busy, 1'b1);
    chk("mid_reset_cs_seen", exp_bus.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx0 = tx_count;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_reset_no_tx", tx_count - tx0, 0);
    seg_end("mid_reset");

    chk("final_bus_queue_empty", exp_bus.size(), 0);
    chk("final_tx_queue_empty", exp_tx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
